mrr_loopback_pop_arbiter: RTL and testbench

Round-robin front end that shares the per-node loopback queue's single pop port among NUM_CHAINS decode chains. It replaces fixed highest-index priority with starvation-free rotation. It serialises one pop at a time through a four-phase handshake on the chain side and a level-request/pulse-ack handshake on the queue side. A timeout guard prevents a missing queue acknowledge from locking up the decode chains.

---
 rtl/mrr_loopback_pop_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_mrr_loopback_pop_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mrr_loopback_pop_arbiter.sv
// Round-robin arbiter that shares the loopback queue's single pop port among
// several decode chains. Chain side: four-phase req/ack. Queue side: level
// request, pulse ack. A timeout guard stops a missing queue ack from hanging
// the decode chains.
module mrr_loopback_pop_arbiter #(
  parameter int unsigned NUM_CHAINS     = 4,
  parameter int unsigned CHIP_ID_LEN    = 16,
  parameter int unsigned MSG_LEN        = 64,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_CHAINS-1:0]             chain_req,
  input  logic [NUM_CHAINS*CHIP_ID_LEN-1:0] chain_chip_id,
  output logic [NUM_CHAINS-1:0]             chain_ack,
  output logic [MSG_LEN-1:0]                chain_msg,
  output logic                              chain_msg_valid,
  output logic                              q_pop_request,
  output logic [CHIP_ID_LEN-1:0]            q_pop_chip_id,
  input  logic                              q_pop_ack,
  input  logic [MSG_LEN-1:0]                q_pop_message,
  output logic                              timeout_err,
  output logic [15:0]                       grant_count
);

  localparam int unsigned IdxW   = (NUM_CHAINS > 1) ? $clog2(NUM_CHAINS) : 1;
  localparam int unsigned TimerW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);
  localparam logic [IdxW-1:0]   IdxLast   = IdxW'(NUM_CHAINS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StReturn,
    StRelease
  } state_e;

  state_e                  state_q, state_d;
  logic [IdxW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]         grant_idx_q, grant_idx_d;
  logic [CHIP_ID_LEN-1:0]  chip_id_q, chip_id_d;
  logic                    req_q, req_d;
  logic [NUM_CHAINS-1:0]   ack_q, ack_d;
  logic [MSG_LEN-1:0]      msg_q, msg_d;
  logic                    valid_q, valid_d;
  logic                    timeout_q, timeout_d;
  logic [15:0]             count_q, count_d;
  logic [TimerW-1:0]       timer_q, timer_d;

  // Per-chain chip ID slices, chain i at the i-th CHIP_ID_LEN field.
  logic [CHIP_ID_LEN-1:0]  chip_ids [NUM_CHAINS];

  for (genvar gi = 0; gi < NUM_CHAINS; gi++) begin : g_chip_ids
    assign chip_ids[gi] = chain_chip_id[(gi+1)*CHIP_ID_LEN-1 -: CHIP_ID_LEN];
  end

  logic                    arb_found;
  logic [IdxW-1:0]         arb_idx;
  logic [IdxW:0]           arb_sum;
  logic [IdxW-1:0]         arb_cand;
  logic [IdxW-1:0]         arb_next_ptr;

  // Round-robin search: first set request at or after rr_ptr, wrapping.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_sum   = '0;
    arb_cand  = '0;
    for (int unsigned i = 0; i < NUM_CHAINS; i++) begin
      arb_sum = {1'b0, rr_ptr_q} + (IdxW+1)'(i);
      if (arb_sum >= (IdxW+1)'(NUM_CHAINS)) begin
        arb_sum = arb_sum - (IdxW+1)'(NUM_CHAINS);
      end
      arb_cand = arb_sum[IdxW-1:0];
      if (!arb_found && chain_req[arb_cand]) begin
        arb_found = 1'b1;
        arb_idx   = arb_cand;
      end
    end
    arb_next_ptr = (arb_idx == IdxLast) ? '0 : arb_idx + 1'b1;
  end

  // Next-state and registered-output logic for the pop transaction FSM.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_idx_d = grant_idx_q;
    chip_id_d   = chip_id_q;
    req_d       = req_q;
    ack_d       = ack_q;
    msg_d       = msg_q;
    valid_d     = valid_q;
    timeout_d   = 1'b0;
    count_d     = count_q;
    timer_d     = timer_q;

    unique case (state_q)
      StIdle: begin
        if (arb_found) begin
          grant_idx_d = arb_idx;
          chip_id_d   = chip_ids[arb_idx];
          rr_ptr_d    = arb_next_ptr;
          req_d       = 1'b1;
          timer_d     = '0;
          state_d     = StIssue;
        end
      end
      StIssue: begin
        // Ack is checked first so a same-cycle ack beats the timeout.
        if (q_pop_ack) begin
          req_d              = 1'b0;
          msg_d              = q_pop_message;
          valid_d            = 1'b1;
          ack_d              = '0;
          ack_d[grant_idx_q] = 1'b1;
          count_d            = count_q + 16'd1;
          state_d            = StReturn;
        end else if (timer_q == TimerLast) begin
          req_d              = 1'b0;
          msg_d              = '0;
          valid_d            = 1'b0;
          timeout_d          = 1'b1;
          ack_d              = '0;
          ack_d[grant_idx_q] = 1'b1;
          count_d            = count_q + 16'd1;
          state_d            = StReturn;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StReturn: begin
        // Only the granted chain's request matters here.
        if (!chain_req[grant_idx_q]) begin
          ack_d   = '0;
          msg_d   = '0;
          valid_d = 1'b0;
          state_d = StRelease;
        end
      end
      StRelease: begin
        timer_d = '0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      grant_idx_q <= '0;
      chip_id_q   <= '0;
      req_q       <= 1'b0;
      ack_q       <= '0;
      msg_q       <= '0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
      count_q     <= '0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_idx_q <= grant_idx_d;
      chip_id_q   <= chip_id_d;
      req_q       <= req_d;
      ack_q       <= ack_d;
      msg_q       <= msg_d;
      valid_q     <= valid_d;
      timeout_q   <= timeout_d;
      count_q     <= count_d;
      timer_q     <= timer_d;
    end
  end

  assign chain_ack       = ack_q;
  assign chain_msg       = msg_q;
  assign chain_msg_valid = valid_q;
  assign q_pop_request   = req_q;
  assign q_pop_chip_id   = chip_id_q;
  assign timeout_err     = timeout_q;
  assign grant_count     = count_q;

endmodule

// File: tb/tb_mrr_loopback_pop_arbiter.sv
// Directed bench for mrr_loopback_pop_arbiter with a short timeout.
module tb_mrr_loopback_pop_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  chain_req;
  logic [63:0] chain_chip_id;
  logic [3:0]  chain_ack;
  logic [63:0] chain_msg;
  logic        chain_msg_valid;
  logic        q_pop_request;
  logic [15:0] q_pop_chip_id;
  logic        q_pop_ack;
  logic [63:0] q_pop_message;
  logic        timeout_err;
  logic [15:0] grant_count;

  int total = 0;
  int bad   = 0;

  mrr_loopback_pop_arbiter #(
    .NUM_CHAINS    (4),
    .CHIP_ID_LEN   (16),
    .MSG_LEN       (64),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .chain_req      (chain_req),
    .chain_chip_id  (chain_chip_id),
    .chain_ack      (chain_ack),
    .chain_msg      (chain_msg),
    .chain_msg_valid(chain_msg_valid),
    .q_pop_request  (q_pop_request),
    .q_pop_chip_id  (q_pop_chip_id),
    .q_pop_ack      (q_pop_ack),
    .q_pop_message  (q_pop_message),
    .timeout_err    (timeout_err),
    .grant_count    (grant_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst_n;
    logic [3:0]  req;
    logic        qack;
    logic [63:0] qmsg;
    logic [3:0]  e_ack;
    logic        e_qreq;
    logic        e_valid;
    logic        e_to;
    logic [15:0] e_cnt;
    logic [15:0] e_id;
    logic [63:0] e_msg;
  } vec_t;

  vec_t vecs [10];

  function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic qa,
                              input logic [63:0] qm, input logic [3:0] ea, input logic eq,
                              input logic ev, input logic et, input logic [15:0] ec,
                              input logic [15:0] ei, input logic [63:0] em);
    vec_t v;
    v.rst_n = r;  v.req = rq;    v.qack = qa;    v.qmsg = qm;
    v.e_ack = ea; v.e_qreq = eq; v.e_valid = ev; v.e_to = et;
    v.e_cnt = ec; v.e_id = ei;   v.e_msg = em;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic int onehot_idx(input logic [3:0] v);
    int r = -1;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          order [5];
    int          ngr, cyc, hi, pulses, k;
    logic        prev_req, prev_ack_any, seen, to_at_ack;
    logic [102:0] act_v, exp_v;

    rst_n         = 1'b0;
    chain_req     = '0;
    q_pop_ack     = 1'b0;
    q_pop_message = '0;
    chain_chip_id = {16'h00D3, 16'h00A5, 16'h00B1, 16'h00C0};

    // Single chain 2 transaction, queue acks 3 cycles after request, then a stray ack.
    vecs[0] = mk(0, 4'b0000, 0, 64'h0,    4'b0000, 0, 0, 0, 16'd0, 16'h0000, 64'h0);
    vecs[1] = mk(1, 4'b0100, 0, 64'h0,    4'b0000, 1, 0, 0, 16'd0, 16'h00A5, 64'h0);
    vecs[2] = mk(1, 4'b0100, 0, 64'h0,    4'b0000, 1, 0, 0, 16'd0, 16'h00A5, 64'h0);
    vecs[3] = mk(1, 4'b0100, 0, 64'h0,    4'b0000, 1, 0, 0, 16'd0, 16'h00A5, 64'h0);
    vecs[4] = mk(1, 4'b0100, 1, 64'h1234, 4'b0100, 0, 1, 0, 16'd1, 16'h00A5, 64'h1234);
    vecs[5] = mk(1, 4'b0100, 0, 64'h0,    4'b0100, 0, 1, 0, 16'd1, 16'h00A5, 64'h1234);
    vecs[6] = mk(1, 4'b0000, 0, 64'h0,    4'b0000, 0, 0, 0, 16'd1, 16'h00A5, 64'h0);
    vecs[7] = mk(1, 4'b0000, 0, 64'h0,    4'b0000, 0, 0, 0, 16'd1, 16'h00A5, 64'h0);
    vecs[8] = mk(1, 4'b0000, 1, 64'hFFFF, 4'b0000, 0, 0, 0, 16'd1, 16'h00A5, 64'h0);
    vecs[9] = mk(1, 4'b0000, 0, 64'h0,    4'b0000, 0, 0, 0, 16'd1, 16'h00A5, 64'h0);

    for (int i = 0; i < 10; i++) begin
      rst_n         = vecs[i].rst_n;
      chain_req     = vecs[i].req;
      q_pop_ack     = vecs[i].qack;
      q_pop_message = vecs[i].qmsg;
      step();
      act_v = {chain_ack, q_pop_request, chain_msg_valid, timeout_err, grant_count,
               q_pop_chip_id, chain_msg};
      exp_v = {vecs[i].e_ack, vecs[i].e_qreq, vecs[i].e_valid, vecs[i].e_to, vecs[i].e_cnt,
               vecs[i].e_id, vecs[i].e_msg};
      check($sformatf("vec%0d", i), {25'd0, act_v}, {25'd0, exp_v});
    end
    q_pop_ack = 1'b0;

    // Rotation: all chains requesting, each releases right after its ack.
    rst_n = 1'b0; chain_req = '0; step(); rst_n = 1'b1;
    ngr = 0; cyc = 0; prev_req = 1'b0; prev_ack_any = 1'b0;
    for (int i = 0; i < 5; i++) order[i] = -1;
    while (ngr < 5 && cyc < 200) begin
      chain_req     = 4'b1111 & ~chain_ack;
      q_pop_ack     = q_pop_request && prev_req;
      q_pop_message = 64'h100 + 64'(ngr);
      prev_req      = q_pop_request;
      step();
      cyc++;
      if (chain_ack != 4'b0000 && !prev_ack_any) begin
        order[ngr] = onehot_idx(chain_ack);
        ngr++;
      end
      prev_ack_any = (chain_ack != 4'b0000);
    end
    for (int i = 0; i < 5; i++) check($sformatf("rr_order%0d", i), 128'(order[i]), 128'(i % 4));
    check("rr_grant_count", 128'(grant_count), 128'd5);
    q_pop_ack = 1'b0;

    // Queue never acks: request held 8 cycles, single timeout pulse, empty message.
    rst_n = 1'b0; chain_req = '0; step(); rst_n = 1'b1;
    chain_req = 4'b0001; q_pop_message = 64'hDEAD_BEEF;
    hi = 0; pulses = 0; seen = 1'b0; to_at_ack = 1'b0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (q_pop_request) hi++;
      if (timeout_err) pulses++;
      if (chain_ack != 4'b0000 && !seen) begin
        seen      = 1'b1;
        to_at_ack = timeout_err;
        check("to_ack", 128'(chain_ack), 128'h1);
        check("to_valid", 128'(chain_msg_valid), 128'h0);
        check("to_msg", 128'(chain_msg), 128'h0);
      end
      chain_req = seen ? 4'b0000 : 4'b0001;
    end
    check("to_req_cycles", 128'(hi), 128'd8);
    check("to_pulses", 128'(pulses), 128'd1);
    check("to_pulse_at_return", 128'(to_at_ack), 128'd1);

    // Ack on the timer's last cycle wins over the timeout.
    rst_n = 1'b0; chain_req = '0; step(); rst_n = 1'b1;
    chain_req = 4'b0001; q_pop_message = 64'hC0FFEE;
    k = 0; pulses = 0; seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (q_pop_request) k++;
      if (timeout_err) pulses++;
      if (chain_ack != 4'b0000 && !seen) begin
        seen = 1'b1;
        check("co_ack", 128'(chain_ack), 128'h1);
        check("co_valid", 128'(chain_msg_valid), 128'h1);
        check("co_msg", 128'(chain_msg), 128'hC0FFEE);
      end
      q_pop_ack = q_pop_request && (k == 8);
      chain_req = seen ? 4'b0000 : 4'b0001;
    end
    q_pop_ack = 1'b0;
    check("co_req_cycles", 128'(k), 128'd8);
    check("co_no_timeout", 128'(pulses), 128'd0);

    // Reset during ISSUE restarts rotation at chain 0.
    chain_req = 4'b0100;
    step();
    step();
    check("rst_pre_req", 128'(q_pop_request), 128'h1);
    rst_n = 1'b0; chain_req = 4'b0000;
    step();
    check("rst_req", 128'(q_pop_request), 128'h0);
    check("rst_ack", 128'(chain_ack), 128'h0);
    check("rst_count", 128'(grant_count), 128'h0);
    rst_n = 1'b1; chain_req = 4'b1010;
    step();
    check("rst_regrant_id", 128'(q_pop_chip_id), 128'h00B1);
    q_pop_ack = 1'b1; q_pop_message = 64'h77;
    step();
    q_pop_ack = 1'b0;
    check("rst_regrant_ack", 128'(chain_ack), 128'h2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
